// File: rtl/blake_pkg.sv
// Shared BLAKE2s constants and rotate helpers, used by the forward G
// and by its inverse.
package blake_pkg;

  localparam int BLAKE_W = 32;

  localparam int ROT_16 = 16;
  localparam int ROT_12 = 12;
  localparam int ROT_8  = 8;
  localparam int ROT_7  = 7;

  typedef logic [BLAKE_W-1:0] word_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
  } quad_t;

  function automatic word_t rotl(word_t x, int n);
    return (x << n) | (x >> (BLAKE_W - n));
  endfunction

  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (BLAKE_W - n));
  endfunction

endpackage

// File: rtl/g_inv_half.sv
// Combinational inverse of one G half-mix; RB/RD are the left-rotate
// amounts that undo the forward right-rotates on b and d.
module g_inv_half
  import blake_pkg::*;
#(
  parameter int RB = ROT_7,
  parameter int RD = ROT_8
) (
  input  logic [BLAKE_W-1:0] a_i,
  input  logic [BLAKE_W-1:0] b_i,
  input  logic [BLAKE_W-1:0] c_i,
  input  logic [BLAKE_W-1:0] d_i,
  input  logic [BLAKE_W-1:0] m_i,
  output logic [BLAKE_W-1:0] a_o,
  output logic [BLAKE_W-1:0] b_o,
  output logic [BLAKE_W-1:0] c_o,
  output logic [BLAKE_W-1:0] d_o
);

  assign b_o = rotl(b_i, RB) ^ c_i;
  assign c_o = c_i - d_i;
  assign d_o = rotl(d_i, RD) ^ a_i;
  assign a_o = a_i - b_o - m_i;

endmodule

// File: rtl/g_inverse.sv
// Two-stage valid/ready pipeline inverting the BLAKE2s G mix.
// Define G_INV_STATS_EN to add the Cnt_O completed-result counter.
module g_inverse
  import blake_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_Valid_I,
  output logic              In_Ready_O,
  input  logic [WORD_W-1:0] A_I,
  input  logic [WORD_W-1:0] B_I,
  input  logic [WORD_W-1:0] C_I,
  input  logic [WORD_W-1:0] D_I,
  input  logic [WORD_W-1:0] X_I,
  input  logic [WORD_W-1:0] Y_I,
  output logic              Out_Valid_O,
  input  logic              Out_Ready_I,
  output logic [WORD_W-1:0] A_O,
  output logic [WORD_W-1:0] B_O,
  output logic [WORD_W-1:0] C_O,
  output logic [WORD_W-1:0] D_O
`ifdef G_INV_STATS_EN
  ,
  output logic [31:0]       Cnt_O
`endif
);

  if (WORD_W != BLAKE_W) begin : g_bad_width
    $error("g_inverse: only WORD_W=32 is supported");
  end

  logic  v1_q, v1_d;
  logic  v2_q, v2_d;
  logic  adv1, adv2;
  quad_t s1_q, s1_n;
  quad_t s2_q, s2_n;
  word_t x_q;

  // Stage 2 frees up when empty or its result leaves this cycle.
  assign adv2       = !v2_q || Out_Ready_I;
  assign adv1       = !v1_q || adv2;
  assign In_Ready_O = adv1;

  g_inv_half #(
    .RB (ROT_7),
    .RD (ROT_8)
  ) u_half_lo (
    .a_i (A_I),
    .b_i (B_I),
    .c_i (C_I),
    .d_i (D_I),
    .m_i (Y_I),
    .a_o (s1_n.a),
    .b_o (s1_n.b),
    .c_o (s1_n.c),
    .d_o (s1_n.d)
  );

  g_inv_half #(
    .RB (ROT_12),
    .RD (ROT_16)
  ) u_half_hi (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .c_i (s1_q.c),
    .d_i (s1_q.d),
    .m_i (x_q),
    .a_o (s2_n.a),
    .b_o (s2_n.b),
    .c_o (s2_n.c),
    .d_o (s2_n.d)
  );

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (adv1) v1_d = In_Valid_I;
    if (adv2) v2_d = v1_q;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      x_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (adv1 && In_Valid_I) begin
        s1_q <= s1_n;
        x_q  <= X_I;
      end
      if (adv2 && v1_q) s2_q <= s2_n;
    end
  end

  assign Out_Valid_O = v2_q;
  assign A_O         = s2_q.a;
  assign B_O         = s2_q.b;
  assign C_O         = s2_q.c;
  assign D_O         = s2_q.d;

`ifdef G_INV_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + 32'd1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                     cnt_q <= '0;
    else if (v2_q && Out_Ready_I) cnt_q <= cnt_d;
  end

  assign Cnt_O = cnt_q;
`endif

endmodule
